ransac_nios_debug_monitor_mem: RTL and testbench
================================================

# ransac_nios_debug_monitor_mem

Debug-monitor memory engine sitting directly downstream of the Nios II JTAG debug module wrapper's system-clock stage. It consumes `jdo` and the `take_action_ocimem_*` / `take_no_action_ocimem_a` strobes, performs word reads and writes on a local debug RAM, and returns `MonDReg`, `monitor_ready` and `monitor_error` to the wrapper. The CPU shares the same RAM through a simple slave port with waitrequest.

## Interface
- `DEPTH`, 256: RAM words; power of two, 16 to 65536.
- `AW`, 8: word-address width, equal to log2(DEPTH).
- `PROT_WORDS`, 32: size of the protected low region. Used only when the configuration macro is defined.
- `clk` in 1: single clock. Ports use the codebase names. One clock only.
- `reset` in 1: synchronous, active-high.
- `jdo` in 38: JTAG data from the wrapper.
- `take_action_ocimem_a` in 1: address-load command strobe.
- `take_action_ocimem_b` in 1: write-data command strobe.
- `take_no_action_ocimem_a` in 1: read-next command strobe.
- `debugack` in 1: CPU is in debug mode.
- `cpu_address` in AW: CPU word address.
- `cpu_read` in 1: CPU read request.
- `cpu_write` in 1: CPU write request.
- `cpu_writedata` in 32: CPU write data.
- `cpu_readdata` out 32: CPU read data.
- `cpu_waitrequest` out 1: CPU stall.
- `MonDReg` out 32: monitor data register.
- `monitor_ready` out 1: high when the engine is idle and the last result is valid.
- `monitor_error` out 1: sticky error.

## Operation
- `MonAReg` is an internal 16-bit word-address register.
- **Address-load command** (`take_action_ocimem_a`):
  - Sets `MonAReg` to `jdo[17:2]`.
  - If `jdo[34]` is 1, a read is launched at the new address.
  - Clears `monitor_error` before the new command is evaluated.
- **Read-next command** (`take_no_action_ocimem_a`): reads at `MonAReg`, then increments `MonAReg`.
- **Write command** (`take_action_ocimem_b`): writes `jdo[34:3]` at `MonAReg`, then increments `MonAReg`.
- **Increment rule**: 16-bit, wraps from 0xFFFF to 0x0000.
- **Strobe priority**: if several strobes arrive in the same cycle, priority is ocimem_a, then ocimem_b, then no_action_a. Lower-priority strobes are dropped and no error is raised.
- **Out of range**: if `MonAReg` is DEPTH or more at issue:
  - no RAM access takes place;
  - `monitor_error` is set;
  - `MonDReg` is unchanged;
  - the address still increments.
- **Busy**: a command arriving while `monitor_ready` is 0 is ignored and sets `monitor_error`. This does not apply to ocimem_a, which is always accepted.
- **FSM states**:
  - IDLE → REQ on an accepted JTAG access.
  - REQ → IDLE after a write is granted.
  - REQ → RDATA after a read is granted.
  - RDATA → IDLE, with `MonDReg` loaded from RAM output.
- **Arbitration**: REQ is granted in the first cycle in which the JTAG side wins.
  - JTAG wins a conflict with a CPU access only if the CPU was granted the previous cycle (round-robin).
  - Otherwise the CPU wins.
  - A JTAG request is therefore stalled for at most one cycle.
- **CPU port**:
  - `cpu_waitrequest` is asserted combinationally when `cpu_read` or `cpu_write` is high and the JTAG side wins that cycle.
  - Reads have a fixed 1-cycle latency after acceptance; `cpu_readdata` is held until the next accepted read.
  - `cpu_read` and `cpu_write` high together are treated as a write.
  - The RAM is single-port and synchronous-read.
- **Reset**:
  - Values after reset: FSM IDLE, `MonAReg`=0, `MonDReg`=0, `monitor_ready`=1, `monitor_error`=0, `cpu_readdata`=0, round-robin pointer set to CPU.
  - RAM contents are not reset.
  - A reset arriving mid-operation aborts the access. A write completes only if its grant cycle came before the reset.

## Timing
- **JTAG read, no conflict**: strobe in cycle N. `monitor_ready` is low from N+1. RAM access happens in N+1. `MonDReg` is valid and `monitor_ready` is high at N+3.
- **JTAG write, no conflict**: strobe in cycle N. RAM is written in N+1. `monitor_ready` is high at N+2.
- **JTAG under conflict**: each lost arbitration cycle adds one cycle to the latency.
- **CPU access**: accepted in the cycle where `cpu_waitrequest` is low. Read data is valid the next cycle.
- **Errors**: `monitor_error` is registered and visible the cycle after the command that caused it.

## Configuration
- `RANSAC_NIOS_DBGMEM_WRITE_PROTECT_EN`
- **Defined**:
  - A JTAG write to a word address below PROT_WORDS while `debugack`=0 is rejected: no RAM write, `monitor_error` set, address still increments.
  - CPU writes to the protected region are always allowed.
- **Undefined**: no protection; `debugack` is ignored.

## Test plan
- Address-load with `jdo[17:2]`=0x0005 and `jdo[34]`=1 after a CPU write of 0xDEADBEEF at address 5 → `MonDReg`=0xDEADBEEF at N+3, `monitor_ready` high, `MonAReg`=5.
- ocimem_b twice with data 0x11111111 then 0x22222222, starting at address 7 → CPU reads 0x11111111 at address 7 and 0x22222222 at address 8, `MonAReg`=9.
- Continuous `cpu_read` with a JTAG write pending → `cpu_waitrequest` high for exactly 1 cycle, JTAG completes within 3 cycles, CPU data correct.
- Address 0x0100 with DEPTH=256, then read-next → `monitor_error`=1, `MonDReg` unchanged, `MonAReg`=0x0101; next ocimem_a clears the error.
- Read-next issued one cycle after a read → ignored, `monitor_error`=1. `MonAReg` wrap: 0xFFFF with read-next → 0x0000.
- Macro defined: write at address 3 with `debugack`=0 → rejected with error, RAM unchanged. Same write with `debugack`=1 → RAM written. Reset asserted in REQ → `monitor_ready`=1, no RAM write.

Source files
------------

// File: rtl/ransac_nios_debug_monitor_mem.sv
// ransac_nios_debug_monitor_mem
//
// Debug-monitor memory engine behind the Nios II JTAG debug wrapper. JTAG
// commands (address load, write, read-next) perform word accesses on a local
// single-port, synchronous-read debug RAM. The CPU shares that RAM through a
// slave port with waitrequest.
//
// Optional feature: define RANSAC_NIOS_DBGMEM_WRITE_PROTECT_EN to reject JTAG
// writes below PROT_WORDS while debugack is low.
//
// Ports
//   clk, reset               single clock, synchronous active-high reset
//   jdo[37:0]                JTAG data: [17:2] word address, [34] read-on-load,
//                            [34:3] write data
//   take_action_ocimem_a     address-load command strobe
//   take_action_ocimem_b     write command strobe
//   take_no_action_ocimem_a  read-next command strobe
//   debugack                 CPU is in debug mode
//   cpu_address/read/write/writedata, cpu_readdata, cpu_waitrequest
//                            CPU slave port
//   MonDReg                  monitor data register
//   monitor_ready            engine idle, last result valid
//   monitor_error            sticky error, cleared by an address load
//   dbg_state, dbg_mon_a_reg FSM state and internal word-address register
//
// CPU handshake: a request (cpu_read or cpu_write high) is accepted on the
// rising edge that ends a cycle in which cpu_waitrequest is low; the master
// holds address/data/command stable while cpu_waitrequest is high. Read data
// appears on cpu_readdata in the cycle after acceptance and is held until the
// next accepted read. Read and write together count as a write.
module ransac_nios_debug_monitor_mem #(
  parameter int DEPTH      = 256,
  parameter int AW         = 8,
  parameter int PROT_WORDS = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [37:0]   jdo,
  input  logic          take_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  input  logic          take_no_action_ocimem_a,
  input  logic          debugack,
  input  logic [AW-1:0] cpu_address,
  input  logic          cpu_read,
  input  logic          cpu_write,
  input  logic [31:0]   cpu_writedata,
  output logic [31:0]   cpu_readdata,
  output logic          cpu_waitrequest,
  output logic [31:0]   MonDReg,
  output logic          monitor_ready,
  output logic          monitor_error,
  output logic [1:0]    dbg_state,
  output logic [15:0]   dbg_mon_a_reg
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_RDATA = 2'd2;

  // 17-bit bounds so DEPTH = 65536 still compares correctly against 16 bits.
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  logic [1:0]    state, state_d;
  logic [15:0]   mon_a_reg, mon_a_d;
  logic [31:0]   mon_d_d;
  logic          err_d;
  logic          op_write, op_write_d;
  logic [AW-1:0] op_addr, op_addr_d;
  logic [31:0]   op_data, op_data_d;

  logic          last_cpu_grant;
  logic          cpu_req, jtag_grant, cpu_grant;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_q;
  logic          cpu_rd_valid;
  logic [31:0]   cpu_rd_hold;

  logic          cmd_rw;
  logic          prot_block;
  logic          load_in_range, mon_in_range;

  logic [31:0]   mem [DEPTH];

  // Lower-priority strobes are dropped silently when ocimem_a is present.
  assign cmd_rw = !take_action_ocimem_a &&
                  (take_action_ocimem_b || take_no_action_ocimem_a);

  assign load_in_range = ({1'b0, jdo[17:2]} < DEPTH_L);
  assign mon_in_range  = ({1'b0, mon_a_reg} < DEPTH_L);

`ifdef RANSAC_NIOS_DBGMEM_WRITE_PROTECT_EN
  localparam logic [16:0] PROT_L = 17'(PROT_WORDS);
  assign prot_block = take_action_ocimem_b && !debugack &&
                      ({1'b0, mon_a_reg} < PROT_L);
`else
  logic unused_debugack;
  assign unused_debugack = debugack;
  assign prot_block      = 1'b0;
`endif

  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[1:0]};

  // Round-robin: a pending JTAG access yields to the CPU unless the CPU was
  // granted last cycle, so JTAG waits at most one cycle. A reset cycle never
  // grants JTAG, which is what aborts a write still waiting in REQ.
  assign cpu_req         = cpu_read || cpu_write;
  assign jtag_grant      = !reset && (state == ST_REQ) && (!cpu_req || last_cpu_grant);
  assign cpu_grant       = cpu_req && !jtag_grant;
  assign cpu_waitrequest = cpu_req && jtag_grant;

  assign ram_we    = jtag_grant ? op_write : (cpu_grant && cpu_write);
  assign ram_addr  = jtag_grant ? op_addr  : cpu_address;
  assign ram_wdata = jtag_grant ? op_data  : cpu_writedata;

  // Debug RAM: contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_cpu_grant <= 1'b0;
      cpu_rd_valid   <= 1'b0;
      cpu_rd_hold    <= '0;
    end else begin
      last_cpu_grant <= cpu_grant;
      cpu_rd_valid   <= cpu_grant && !cpu_write;
      if (cpu_rd_valid) cpu_rd_hold <= ram_q;
    end
  end

  // Fresh RAM data in the cycle after acceptance, the held copy afterwards.
  assign cpu_readdata = cpu_rd_valid ? ram_q : cpu_rd_hold;

  always_comb begin
    state_d    = state;
    mon_a_d    = mon_a_reg;
    mon_d_d    = MonDReg;
    err_d      = monitor_error;
    op_write_d = op_write;
    op_addr_d  = op_addr;
    op_data_d  = op_data;

    case (state)
      ST_REQ:   if (jtag_grant) state_d = op_write ? ST_IDLE : ST_RDATA;
      ST_RDATA: begin
        state_d = ST_IDLE;
        mon_d_d = ram_q;
      end
      default:  state_d = ST_IDLE;
    endcase

    if (take_action_ocimem_a) begin
      // Always accepted; a read here replaces anything still in flight.
      mon_a_d = jdo[17:2];
      err_d   = 1'b0;
      if (jdo[34]) begin
        if (load_in_range) begin
          state_d    = ST_REQ;
          op_write_d = 1'b0;
          op_addr_d  = jdo[AW+1:2];
        end else begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
    end else if (cmd_rw) begin
      if (!monitor_ready) begin
        err_d = 1'b1;
      end else begin
        mon_a_d = mon_a_reg + 16'd1;
        if (!mon_in_range || prot_block) begin
          err_d = 1'b1;
        end else begin
          state_d    = ST_REQ;
          op_write_d = take_action_ocimem_b;
          op_addr_d  = mon_a_reg[AW-1:0];
          op_data_d  = jdo[34:3];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      mon_a_reg     <= '0;
      MonDReg       <= '0;
      monitor_error <= 1'b0;
      op_write      <= 1'b0;
      op_addr       <= '0;
      op_data       <= '0;
    end else begin
      state         <= state_d;
      mon_a_reg     <= mon_a_d;
      MonDReg       <= mon_d_d;
      monitor_error <= err_d;
      op_write      <= op_write_d;
      op_addr       <= op_addr_d;
      op_data       <= op_data_d;
    end
  end

  assign monitor_ready = (state == ST_IDLE);
  assign dbg_state     = state;
  assign dbg_mon_a_reg = mon_a_reg;

endmodule

// File: tb/tb_ransac_nios_debug_monitor_mem.sv
`timescale 1ns/1ps
module tb_ransac_nios_debug_monitor_mem;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int PROT  = 32;

  localparam int OP_LOAD  = 0;
  localparam int OP_WRITE = 1;
  localparam int OP_NEXT  = 2;

  logic          clk;
  logic          reset;
  logic [37:0]   jdo;
  logic          take_action_ocimem_a;
  logic          take_action_ocimem_b;
  logic          take_no_action_ocimem_a;
  logic          debugack;
  logic [AW-1:0] cpu_address;
  logic          cpu_read;
  logic          cpu_write;
  logic [31:0]   cpu_writedata;
  logic [31:0]   cpu_readdata;
  logic          cpu_waitrequest;
  logic [31:0]   MonDReg;
  logic          monitor_ready;
  logic          monitor_error;
  logic [1:0]    dbg_state;
  logic [15:0]   dbg_mon_a_reg;

  ransac_nios_debug_monitor_mem #(.DEPTH(DEPTH), .AW(AW), .PROT_WORDS(PROT)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .debugack(debugack),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_readdata),
    .cpu_waitrequest(cpu_waitrequest),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .dbg_state(dbg_state), .dbg_mon_a_reg(dbg_mon_a_reg)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] mem_m [DEPTH];
  logic [15:0] m_mon;
  logic        m_err;
  logic [31:0] m_mdr;

  function automatic bit prot_hit(input logic [15:0] a);
`ifdef RANSAC_NIOS_DBGMEM_WRITE_PROTECT_EN
    return (int'(a) < PROT) && !debugack;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_cmd(input int op, input logic [15:0] a, input logic rd,
                           input logic [31:0] d, output int exp_lat);
    exp_lat = 1;
    if (op == OP_LOAD) begin
      m_mon = a;
      m_err = 1'b0;
      if (rd) begin
        if (int'(a) < DEPTH) begin m_mdr = mem_m[a[AW-1:0]]; exp_lat = 3; end
        else m_err = 1'b1;
      end
    end else if (op == OP_WRITE) begin
      if (int'(m_mon) < DEPTH && !prot_hit(m_mon)) begin
        mem_m[m_mon[AW-1:0]] = d;
        exp_lat = 2;
      end else m_err = 1'b1;
      m_mon = m_mon + 16'd1;
    end else begin
      if (int'(m_mon) < DEPTH) begin m_mdr = mem_m[m_mon[AW-1:0]]; exp_lat = 3; end
      else m_err = 1'b1;
      m_mon = m_mon + 16'd1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    m_mon = '0;
    m_err = 1'b0;
    m_mdr = '0;
  endtask

  task automatic cpu_access(input logic wr, input logic [AW-1:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata);
    int n;
    cpu_address   = addr;
    cpu_writedata = wdata;
    cpu_write     = wr;
    cpu_read      = !wr;
    rdata         = '0;
    n = 0;
    @(negedge clk);
    while (cpu_waitrequest && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8) fail_now("cpu_waitrequest_stuck");
    tick();
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    if (!wr) rdata = cpu_readdata;
  endtask

  task automatic cpu_wr(input logic [AW-1:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    cpu_access(1'b1, addr, data, dummy);
    mem_m[addr] = data;
  endtask

  task automatic cpu_rd_expect(input string name, input logic [AW-1:0] addr,
                               input logic [31:0] exp);
    logic [31:0] got;
    exp_q.push_back(exp);
    cpu_access(1'b0, addr, '0, got);
    check(name, got, exp_q.pop_front());
  endtask

  task automatic jtag_cmd(input int op, input logic [15:0] a, input logic rd,
                          input logic [31:0] d, output int lat);
    jdo = '0;
    if (op == OP_LOAD) begin
      jdo[17:2] = a;
      jdo[34]   = rd;
      take_action_ocimem_a = 1'b1;
    end else if (op == OP_WRITE) begin
      jdo[34:3] = d;
      take_action_ocimem_b = 1'b1;
    end else begin
      take_no_action_ocimem_a = 1'b1;
    end
    tick();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    lat = 1;
    while (!monitor_ready && lat < 20) begin
      tick();
      lat++;
    end
    if (!monitor_ready) fail_now("jtag_ready_timeout");
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          op;
    logic [15:0] a;
    logic        rd;
    logic [31:0] d;
    logic [15:0] exp_mon;
    logic        exp_err;
    logic [31:0] exp_mdr;
    int          exp_lat;
  } vec_t;

  vec_t        vecs[15];
  int          lat, exp_lat, wcnt;
  bit          rd_ok;
  logic [15:0] ra;
  logic        rrd;
  logic [31:0] rdv;
  int          op;

  initial begin
    vecs[0]  = '{OP_LOAD,  16'h0005, 1'b1, 32'h0,        16'h0005, 1'b0, 32'hDEADBEEF, 3};
    vecs[1]  = '{OP_LOAD,  16'h0007, 1'b0, 32'h0,        16'h0007, 1'b0, 32'hDEADBEEF, 1};
    vecs[2]  = '{OP_WRITE, 16'h0000, 1'b0, 32'h11111111, 16'h0008, 1'b0, 32'hDEADBEEF, 2};
    vecs[3]  = '{OP_WRITE, 16'h0000, 1'b0, 32'h22222222, 16'h0009, 1'b0, 32'hDEADBEEF, 2};
    vecs[4]  = '{OP_LOAD,  16'h0007, 1'b1, 32'h0,        16'h0007, 1'b0, 32'h11111111, 3};
    vecs[5]  = '{OP_NEXT,  16'h0000, 1'b0, 32'h0,        16'h0008, 1'b0, 32'h11111111, 3};
    vecs[6]  = '{OP_NEXT,  16'h0000, 1'b0, 32'h0,        16'h0009, 1'b0, 32'h22222222, 3};
    vecs[7]  = '{OP_LOAD,  16'h0100, 1'b0, 32'h0,        16'h0100, 1'b0, 32'h22222222, 1};
    vecs[8]  = '{OP_NEXT,  16'h0000, 1'b0, 32'h0,        16'h0101, 1'b1, 32'h22222222, 1};
    vecs[9]  = '{OP_WRITE, 16'h0000, 1'b0, 32'h33333333, 16'h0102, 1'b1, 32'h22222222, 1};
    vecs[10] = '{OP_LOAD,  16'hFFFF, 1'b0, 32'h0,        16'hFFFF, 1'b0, 32'h22222222, 1};
    vecs[11] = '{OP_NEXT,  16'h0000, 1'b0, 32'h0,        16'h0000, 1'b1, 32'h22222222, 1};
    vecs[12] = '{OP_LOAD,  16'h0000, 1'b0, 32'h0,        16'h0000, 1'b0, 32'h22222222, 1};
    vecs[13] = '{OP_WRITE, 16'h0000, 1'b0, 32'hA5A5A5A5, 16'h0001, 1'b0, 32'h22222222, 2};
    vecs[14] = '{OP_LOAD,  16'h0000, 1'b1, 32'h0,        16'h0000, 1'b0, 32'hA5A5A5A5, 3};

    jdo = '0;
    debugack = 1'b1;
    cpu_address = '0;
    cpu_writedata = '0;
    do_reset();

    // Reset state
    check("rst_ready",    32'(monitor_ready), 32'd1);
    check("rst_error",    32'(monitor_error), 32'd0);
    check("rst_mondreg",  MonDReg,            32'd0);
    check("rst_readdata", cpu_readdata,       32'd0);
    check("rst_mon_a",    32'(dbg_mon_a_reg), 32'd0);
    check("rst_state",    32'(dbg_state),     32'd0);

    cpu_wr(8'd5, 32'hDEADBEEF);
    for (int i = 0; i < 15; i++) begin
      jtag_cmd(vecs[i].op, vecs[i].a, vecs[i].rd, vecs[i].d, lat);
      check($sformatf("vec%0d_lat", i),   32'(lat),           32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_mon_a", i), 32'(dbg_mon_a_reg), 32'(vecs[i].exp_mon));
      check($sformatf("vec%0d_error", i), 32'(monitor_error), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_mondreg", i), MonDReg,          vecs[i].exp_mdr);
    end
    cpu_rd_expect("cpu_rd_addr7", 8'd7, 32'h11111111);
    cpu_rd_expect("cpu_rd_addr8", 8'd8, 32'h22222222);
    cpu_rd_expect("cpu_rd_addr0", 8'd0, 32'hA5A5A5A5);

    // Continuous CPU read while a JTAG write is pending: CPU was granted the
    // previous cycle so JTAG takes the first REQ cycle.
    jtag_cmd(OP_LOAD, 16'd20, 1'b0, 32'h0, lat);
    cpu_address = 8'd8;
    cpu_read = 1'b1;
    tick();
    jdo = '0;
    jdo[34:3] = 32'h44444444;
    take_action_ocimem_b = 1'b1;
    wcnt = 0; lat = 0; rd_ok = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      take_action_ocimem_b = 1'b0;
      @(negedge clk);
      if (cpu_waitrequest) wcnt++;
      if (monitor_ready && lat == 0) lat = i;
      if (cpu_readdata !== 32'h22222222) rd_ok = 1'b0;
    end
    tick();
    cpu_read = 1'b0;
    check("conflict1_wait_cycles", 32'(wcnt),  32'd1);
    check("conflict1_jtag_lat",    32'(lat),   32'd2);
    check("conflict1_cpu_data",    32'(rd_ok), 32'd1);
    cpu_rd_expect("conflict1_written", 8'd20, 32'h44444444);

    // CPU request appears in the first REQ cycle with no prior CPU grant:
    // CPU wins once, JTAG wins the next cycle.
    tick();
    tick();
    jdo = '0;
    jdo[34:3] = 32'h66666666;
    take_action_ocimem_b = 1'b1;
    wcnt = 0; lat = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 1) begin
        take_action_ocimem_b = 1'b0;
        cpu_address = 8'd5;
        cpu_read = 1'b1;
      end
      @(negedge clk);
      if (cpu_waitrequest) wcnt++;
      if (monitor_ready && lat == 0) lat = i;
    end
    tick();
    cpu_read = 1'b0;
    check("conflict2_wait_cycles", 32'(wcnt),    32'd1);
    check("conflict2_jtag_lat",    32'(lat),     32'd3);
    check("conflict2_cpu_data",    cpu_readdata, 32'hDEADBEEF);
    cpu_rd_expect("conflict2_written", 8'd21, 32'h66666666);

    // Read-next one cycle after a read launch is ignored and flags an error.
    jdo = '0;
    jdo[17:2] = 16'd5;
    jdo[34] = 1'b1;
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    check("busy_error", 32'(monitor_error), 32'd1);
    check("busy_mon_a", 32'(dbg_mon_a_reg), 32'd5);
    lat = 0;
    while (!monitor_ready && lat < 20) begin tick(); lat++; end
    if (!monitor_ready) fail_now("busy_ready_timeout");
    check("busy_mondreg", MonDReg, 32'hDEADBEEF);

    // Reset while a write waits in REQ aborts it.
    cpu_wr(8'd30, 32'h12345678);
    jtag_cmd(OP_LOAD, 16'd30, 1'b0, 32'h0, lat);
    jdo = '0;
    jdo[34:3] = 32'h55555555;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_ready",   32'(monitor_ready), 32'd1);
    check("midrst_state",   32'(dbg_state),     32'd0);
    check("midrst_mon_a",   32'(dbg_mon_a_reg), 32'd0);
    check("midrst_mondreg", MonDReg,            32'd0);
    check("midrst_rdata",   cpu_readdata,       32'd0);
    cpu_rd_expect("midrst_no_write", 8'd30, 32'h12345678);

`ifdef RANSAC_NIOS_DBGMEM_WRITE_PROTECT_EN
    cpu_wr(8'd3, 32'h0BADF00D);
    debugack = 1'b0;
    jtag_cmd(OP_LOAD, 16'd3, 1'b0, 32'h0, lat);
    jtag_cmd(OP_WRITE, 16'd0, 1'b0, 32'h77777777, lat);
    check("prot_error", 32'(monitor_error), 32'd1);
    check("prot_mon_a", 32'(dbg_mon_a_reg), 32'd4);
    cpu_rd_expect("prot_unchanged", 8'd3, 32'h0BADF00D);
    debugack = 1'b1;
    jtag_cmd(OP_LOAD, 16'd3, 1'b0, 32'h0, lat);
    jtag_cmd(OP_WRITE, 16'd0, 1'b0, 32'h77777777, lat);
    check("unprot_error", 32'(monitor_error), 32'd0);
    cpu_rd_expect("unprot_written", 8'd3, 32'h77777777);
`endif

    // Randomized phase against the transaction-level model.
    do_reset();
    for (int a = 0; a < DEPTH; a++) cpu_wr(8'(a), $urandom);
    for (int it = 0; it < 200; it++) begin
      op = $urandom_range(0, 9);
      if (op <= 1) begin
        cpu_wr(8'($urandom_range(0, DEPTH - 1)), $urandom);
      end else if (op <= 3) begin
        ra = 16'($urandom_range(0, DEPTH - 1));
        cpu_rd_expect($sformatf("rand%0d_cpu_rd", it), ra[AW-1:0], mem_m[ra[AW-1:0]]);
      end else begin
        debugack = 1'($urandom_range(0, 1));
        rdv = $urandom;
        rrd = 1'b0;
        ra = '0;
        if (op <= 5) begin
          case ($urandom_range(0, 7))
            0:       ra = 16'($urandom_range(DEPTH, 65535));
            1:       ra = 16'hFFFE;
            default: begin
              ra  = 16'($urandom_range(0, DEPTH - 1));
              rrd = 1'($urandom_range(0, 1));
            end
          endcase
          op = OP_LOAD;
        end else if (op <= 7) op = OP_WRITE;
        else op = OP_NEXT;
        model_cmd(op, ra, rrd, rdv, exp_lat);
        jtag_cmd(op, ra, rrd, rdv, lat);
        check($sformatf("rand%0d_lat", it),     32'(lat),           32'(exp_lat));
        check($sformatf("rand%0d_mon_a", it),   32'(dbg_mon_a_reg), 32'(m_mon));
        check($sformatf("rand%0d_error", it),   32'(monitor_error), 32'(m_err));
        check($sformatf("rand%0d_mondreg", it), MonDReg,            m_mdr);
      end
    end
    for (int a = 0; a < 16; a++)
      cpu_rd_expect($sformatf("final_rd%0d", a), 8'(a), mem_m[a]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
